// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC readout blocks.
//   idx_w(width) : width of an encoded channel index (at least 1 bit)
//   cnt_w(width) : width of a count that can hold 0..width
//   state_t      : frame decoder FSM states (ACCUM, HOLD)
// -----------------------------------------------------------------------------
package tdc_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Index width; a single-channel build still carries a 1-bit index.
   function automatic int idx_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   // Count width able to represent every value from 0 up to width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/tdc_hit_decoder_if.sv
// -----------------------------------------------------------------------------
// tdc_hit_decoder_if
// Hit-index input stream plus frame-result output stream of tdc_hit_decoder.
//   s_valid/s_ready/s_index/s_last/s_empty : encoded hit beats
//   m_valid/m_ready/m_unencoded/m_count    : reconstructed frame result
//   m_err_range/m_err_dup                  : frame error flags
//   m_dup_cnt                              : only with TDC_HIT_DECODER_DUP_CNT_EN
// Modports: slave = decoder view, master = producer/consumer view.
// -----------------------------------------------------------------------------
interface tdc_hit_decoder_if
   import tdc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = idx_w(WIDTH),
   parameter int CNT_W = cnt_w(WIDTH)
);
   logic             s_valid;
   logic             s_ready;
   logic [IDX_W-1:0] s_index;
   logic             s_last;
   logic             s_empty;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_unencoded;
   logic [CNT_W-1:0] m_count;
   logic             m_err_range;
   logic             m_err_dup;
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
   logic [CNT_W-1:0] m_dup_cnt;

   modport slave (
      input  s_valid, s_index, s_last, s_empty, m_ready,
      output s_ready, m_valid, m_unencoded, m_count, m_err_range, m_err_dup, m_dup_cnt
   );
   modport master (
      output s_valid, s_index, s_last, s_empty, m_ready,
      input  s_ready, m_valid, m_unencoded, m_count, m_err_range, m_err_dup, m_dup_cnt
   );
`else
   modport slave (
      input  s_valid, s_index, s_last, s_empty, m_ready,
      output s_ready, m_valid, m_unencoded, m_count, m_err_range, m_err_dup
   );
   modport master (
      output s_valid, s_index, s_last, s_empty, m_ready,
      input  s_ready, m_valid, m_unencoded, m_count, m_err_range, m_err_dup
   );
`endif
endinterface

// File: rtl/tdc_hit_decoder_onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
// Combinational encoded-index to one-hot decoder with an in-range flag.
//   i_index    : encoded index
//   o_onehot   : one-hot vector, all zero when the index is >= WIDTH
//   o_in_range : index addresses an existing channel
// -----------------------------------------------------------------------------
module onehot_decoder
   import tdc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = idx_w(WIDTH)
) (
   input  logic [IDX_W-1:0] i_index,
   output logic [WIDTH-1:0] o_onehot,
   output logic             o_in_range
);

   // Compare against every channel number; a non-existent channel leaves all bits clear.
   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_onehot[i] = (i_index == IDX_W'(i));
      end
      o_in_range = |o_onehot;
   end

endmodule

// File: rtl/tdc_hit_decoder.sv
// -----------------------------------------------------------------------------
// tdc_hit_decoder
// Accumulates a frame of encoded hit indices into a hit bitmap and emits the
// bitmap, distinct-hit count and error flags when the frame's last beat lands.
//   clk, rst : single clock, synchronous active-high reset
//   io_bus   : tdc_hit_decoder_if.slave (input beat stream + result stream)
// Optional feature: TDC_HIT_DECODER_DUP_CNT_EN adds a saturating repeated-index
// counter reported on m_dup_cnt.
// -----------------------------------------------------------------------------
module tdc_hit_decoder
   import tdc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = idx_w(WIDTH),
   parameter int CNT_W = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   tdc_hit_decoder_if.slave io_bus
);

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err_range;
   logic             r_err_dup;
   logic             r_m_valid;
   logic [WIDTH-1:0] r_m_unencoded;
   logic [CNT_W-1:0] r_m_count;
   logic             r_m_err_range;
   logic             r_m_err_dup;

   logic             w_s_ready;
   logic             w_fire;
   logic             w_load;
   logic             w_hit;
   logic             w_in_range;
   logic             w_dup_hit;
   logic [WIDTH-1:0] w_onehot;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_err_range_nxt;
   logic             w_err_dup_nxt;

`ifdef TDC_HIT_DECODER_DUP_CNT_EN
   logic [CNT_W-1:0] r_dup_cnt;
   logic [CNT_W-1:0] r_m_dup_cnt;
   logic [CNT_W-1:0] w_dup_cnt_nxt;
`endif

   onehot_decoder #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_onehot (
      .i_index    (io_bus.s_index),
      .o_onehot   (w_onehot),
      .o_in_range (w_in_range)
   );

   // Input may advance whenever the result slot is empty or being drained now.
   assign w_s_ready = !r_m_valid || io_bus.m_ready;

   // Frame state updated with the current beat; an empty-marked beat carries no hit.
   always_comb begin
      w_fire          = io_bus.s_valid && w_s_ready;
      w_load          = w_fire && io_bus.s_last;
      w_hit           = w_fire && !io_bus.s_empty;
      w_dup_hit       = w_hit && w_in_range && (|(r_acc & w_onehot));
      w_acc_nxt       = w_hit ? (r_acc | w_onehot) : r_acc;
      w_cnt_nxt       = (w_hit && w_in_range && !w_dup_hit) ? (r_cnt + CNT_W'(1'b1)) : r_cnt;
      w_err_range_nxt = r_err_range | (w_hit && !w_in_range);
      w_err_dup_nxt   = r_err_dup | w_dup_hit;
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
      if (w_dup_hit && (r_dup_cnt != {CNT_W{1'b1}})) begin
         w_dup_cnt_nxt = r_dup_cnt + CNT_W'(1'b1);
      end else begin
         w_dup_cnt_nxt = r_dup_cnt;
      end
`endif
   end

   // Accumulator, result register and ACCUM/HOLD control.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ACCUM;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_err_range   <= 1'b0;
         r_err_dup     <= 1'b0;
         r_m_valid     <= 1'b0;
         r_m_unencoded <= '0;
         r_m_count     <= '0;
         r_m_err_range <= 1'b0;
         r_m_err_dup   <= 1'b0;
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
         r_dup_cnt     <= '0;
         r_m_dup_cnt   <= '0;
`endif
      end else begin
         // A closing beat hands the merged frame to the result slot and restarts.
         if (w_load) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_err_range   <= 1'b0;
            r_err_dup     <= 1'b0;
            r_m_valid     <= 1'b1;
            r_m_unencoded <= w_acc_nxt;
            r_m_count     <= w_cnt_nxt;
            r_m_err_range <= w_err_range_nxt;
            r_m_err_dup   <= w_err_dup_nxt;
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
            r_dup_cnt     <= '0;
            r_m_dup_cnt   <= w_dup_cnt_nxt;
`endif
         end else if (w_fire) begin
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err_range   <= w_err_range_nxt;
            r_err_dup     <= w_err_dup_nxt;
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
            r_dup_cnt     <= w_dup_cnt_nxt;
`endif
         end else begin
            r_acc         <= r_acc;
         end

         case (r_state)
            ACCUM: begin
               if (w_load) begin
                  r_state <= HOLD;
               end else begin
                  r_state <= ACCUM;
               end
            end
            HOLD: begin
               // Drain and reload on the same edge keeps m_valid high.
               if (w_load) begin
                  r_state <= HOLD;
               end else if (io_bus.m_ready) begin
                  r_state   <= ACCUM;
                  r_m_valid <= 1'b0;
               end else begin
                  r_state <= HOLD;
               end
            end
            default: begin
               r_state   <= ACCUM;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.s_ready     = w_s_ready;
   assign io_bus.m_valid     = r_m_valid;
   assign io_bus.m_unencoded = r_m_unencoded;
   assign io_bus.m_count     = r_m_count;
   assign io_bus.m_err_range = r_m_err_range;
   assign io_bus.m_err_dup   = r_m_err_dup;
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
   assign io_bus.m_dup_cnt   = r_m_dup_cnt;
`endif

endmodule

// File: tb/tb_tdc_hit_decoder.sv
// -----------------------------------------------------------------------------
// tb_tdc_hit_decoder
// Scoreboard bench: drives an 8-channel and a 5-channel decoder; each accepted
// frame pushes its expected result, each drained result is popped and compared.
// -----------------------------------------------------------------------------
module tb_tdc_hit_decoder;

   typedef struct {
      logic [7:0] map;
      int         cnt;
      bit         er;
      bit         ed;
      int         dc;
   } exp_t;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   tdc_hit_decoder_if #(.WIDTH(8)) if8 ();
   tdc_hit_decoder_if #(.WIDTH(5)) if5 ();

   tdc_hit_decoder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .io_bus(if8.slave));
   tdc_hit_decoder #(.WIDTH(5)) u_dut5 (.clk(clk), .rst(rst), .io_bus(if5.slave));

   // Reference frame model, one slot per DUT (0 = WIDTH 8, 1 = WIDTH 5).
   logic [7:0] mdl_map [2];
   bit         mdl_er  [2];
   bit         mdl_ed  [2];
   int         mdl_dc  [2];
   int         mdl_w   [2] = '{8, 5};
   int         mdl_max [2] = '{15, 7};
   exp_t       q8[$];
   exp_t       q5[$];
   exp_t       e8;
   exp_t       e5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         mdl_map[d] = 8'h00;
         mdl_er[d]  = 1'b0;
         mdl_ed[d]  = 1'b0;
         mdl_dc[d]  = 0;
      end
   endtask

   task automatic model_beat(input int d, input int idx, input bit last, input bit empty);
      exp_t e;
      if (!empty) begin
         if (idx >= mdl_w[d]) begin
            mdl_er[d] = 1'b1;
         end else if (mdl_map[d][idx]) begin
            mdl_ed[d] = 1'b1;
            if (mdl_dc[d] < mdl_max[d]) mdl_dc[d]++;
         end else begin
            mdl_map[d][idx] = 1'b1;
         end
      end
      if (last) begin
         e.map = mdl_map[d];
         e.cnt = $countones(mdl_map[d]);
         e.er  = mdl_er[d];
         e.ed  = mdl_ed[d];
         e.dc  = mdl_dc[d];
         if (d == 0) q8.push_back(e);
         else        q5.push_back(e);
         mdl_map[d] = 8'h00;
         mdl_er[d]  = 1'b0;
         mdl_ed[d]  = 1'b0;
         mdl_dc[d]  = 0;
      end
   endtask

   // Present one beat at the falling edge, wait for s_ready, accept on the rising edge.
   task automatic send(input int d, input int idx, input bit last, input bit empty);
      int   guard;
      logic rdy;
      guard = 0;
      @(negedge clk);
      if (d == 0) begin
         if8.s_valid = 1'b1; if8.s_index = 3'(idx); if8.s_last = last; if8.s_empty = empty;
      end else begin
         if5.s_valid = 1'b1; if5.s_index = 3'(idx); if5.s_last = last; if5.s_empty = empty;
      end
      #1;
      rdy = (d == 0) ? if8.s_ready : if5.s_ready;
      while (!rdy && guard < 50) begin
         @(negedge clk); #1;
         rdy = (d == 0) ? if8.s_ready : if5.s_ready;
         guard++;
      end
      if (guard >= 50) check_eq("s_ready_timeout", 32'(rdy), 32'd1);
      model_beat(d, idx, last, empty);
      @(posedge clk); #1;
      if (d == 0) if8.s_valid = 1'b0;
      else        if5.s_valid = 1'b0;
      if (last) check_eq("latency_m_valid", (d == 0) ? 32'(if8.m_valid) : 32'(if5.m_valid), 32'd1);
   endtask

   // Scoreboard pop for the 8-channel DUT on each result handshake.
   always @(negedge clk) begin
      if (!rst && if8.m_valid && if8.m_ready) begin
         if (q8.size() == 0) begin
            check_eq("unexpected_result8", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            check_eq("w8_unencoded", 32'(if8.m_unencoded), 32'(e8.map));
            check_eq("w8_count",     32'(if8.m_count),     32'(e8.cnt));
            check_eq("w8_err_range", 32'(if8.m_err_range), 32'(e8.er));
            check_eq("w8_err_dup",   32'(if8.m_err_dup),   32'(e8.ed));
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
            check_eq("w8_dup_cnt",   32'(if8.m_dup_cnt),   32'(e8.dc));
`endif
         end
      end
   end

   // Scoreboard pop for the 5-channel DUT on each result handshake.
   always @(negedge clk) begin
      if (!rst && if5.m_valid && if5.m_ready) begin
         if (q5.size() == 0) begin
            check_eq("unexpected_result5", 32'd1, 32'd0);
         end else begin
            e5 = q5.pop_front();
            check_eq("w5_unencoded", 32'(if5.m_unencoded), 32'(e5.map));
            check_eq("w5_count",     32'(if5.m_count),     32'(e5.cnt));
            check_eq("w5_err_range", 32'(if5.m_err_range), 32'(e5.er));
            check_eq("w5_err_dup",   32'(if5.m_err_dup),   32'(e5.ed));
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
            check_eq("w5_dup_cnt",   32'(if5.m_dup_cnt),   32'(e5.dc));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if8.s_valid = 1'b0; if8.s_index = 3'd0; if8.s_last = 1'b0; if8.s_empty = 1'b0; if8.m_ready = 1'b0;
      if5.s_valid = 1'b0; if5.s_index = 3'd0; if5.s_last = 1'b0; if5.s_empty = 1'b0; if5.m_ready = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_m_valid",   32'(if8.m_valid),     32'd0);
      check_eq("rst_unencoded", 32'(if8.m_unencoded), 32'd0);
      check_eq("rst_count",     32'(if8.m_count),     32'd0);
      check_eq("rst_err_range", 32'(if8.m_err_range), 32'd0);
      check_eq("rst_err_dup",   32'(if8.m_err_dup),   32'd0);
      check_eq("rst_s_ready",   32'(if8.s_ready),     32'd1);
`ifdef TDC_HIT_DECODER_DUP_CNT_EN
      check_eq("rst_dup_cnt",   32'(if8.m_dup_cnt),   32'd0);
`endif
      rst = 1'b0;
      if8.m_ready = 1'b1;
      if5.m_ready = 1'b1;

      // Basic frame, duplicate, empty frame, illegal empty mid-frame.
      send(0, 3, 1'b0, 1'b0); send(0, 5, 1'b0, 1'b0); send(0, 0, 1'b1, 1'b0);
      send(0, 2, 1'b0, 1'b0); send(0, 2, 1'b1, 1'b0);
      send(0, 0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check_eq("empty_one_cycle", 32'(if8.m_valid), 32'd0);
      send(0, 1, 1'b0, 1'b0); send(0, 0, 1'b0, 1'b1); send(0, 4, 1'b1, 1'b0);

      // Duplicate counter saturation, full bitmap, back-to-back single-beat frames.
      for (int i = 0; i < 17; i++) send(0, 0, (i == 16), 1'b0);
      for (int i = 0; i < 8; i++)  send(0, i, (i == 7), 1'b0);
      for (int i = 0; i < 4; i++)  send(0, i, 1'b1, 1'b0);

      // Non-power-of-two width: out-of-range indices are dropped and flagged.
      send(1, 7, 1'b0, 1'b0); send(1, 1, 1'b1, 1'b0);
      send(1, 4, 1'b1, 1'b0);
      send(1, 5, 1'b1, 1'b0);

      // Backpressure: result held, input stalled, then drain and reload together.
      repeat (2) @(posedge clk);
      #1;
      if8.m_ready = 1'b0;
      send(0, 6, 1'b1, 1'b0);
      @(negedge clk);
      if8.s_valid = 1'b1; if8.s_index = 3'd3; if8.s_last = 1'b1; if8.s_empty = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check_eq("bp_s_ready",   32'(if8.s_ready),     32'd0);
         check_eq("bp_m_valid",   32'(if8.m_valid),     32'd1);
         check_eq("bp_unencoded", 32'(if8.m_unencoded), 32'h40);
         check_eq("bp_count",     32'(if8.m_count),     32'd1);
      end
      if8.m_ready = 1'b1;
      model_beat(0, 3, 1'b1, 1'b0);
      @(posedge clk); #1;
      if8.s_valid = 1'b0;
      check_eq("bp_new_valid",     32'(if8.m_valid),     32'd1);
      check_eq("bp_new_unencoded", 32'(if8.m_unencoded), 32'h08);

      // Reset in the middle of a frame discards the partial bitmap.
      repeat (3) @(posedge clk);
      #1;
      send(0, 6, 1'b0, 1'b0);
      rst = 1'b1;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("midrst_m_valid", 32'(if8.m_valid), 32'd0);
      send(0, 1, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_eq("midrst_drained", 32'(if8.m_valid), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check_eq("q8_empty", 32'(q8.size()), 32'd0);
      check_eq("q5_empty", 32'(q5.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
